// File: rtl/inv_cipher_ctrl_pkg.sv
// Shared constants, FSM encoding and bytewise GF(2^8) helpers for the AES-128 inverse cipher.
package inv_cipher_ctrl_pkg;

  localparam int unsigned AesNr   = 10;
  localparam int unsigned AesBlkW = 128;
  localparam int unsigned RkIdxW  = 4;

  localparam logic [RkIdxW-1:0] RkIdxLast = 4'(AesNr);
  localparam logic [RkIdxW-1:0] RndFirst  = 4'(AesNr - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRound = 2'd1,
    StFinal = 2'd2,
    StDone  = 2'd3
  } ctrl_state_e;

  // Element 0 sits in the MSBs, so byte n of the block is simply blk[n].
  typedef logic [0:15][7:0] aes_blk_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // b^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h01;
    p   = b;
    for (int unsigned i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      acc = gf_mul(acc, p);
    end
    return acc;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] a;
    a = {s[1:0], s[7:2]} ^ {s[4:0], s[7:5]} ^ {s[6:0], s[7]} ^ 8'h05;
    return gf_inv(a);
  endfunction

  function automatic aes_blk_t inv_shift_rows(input aes_blk_t s);
    aes_blk_t o;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[4'(4 * c + r)] = s[4'(4 * ((c + 4 - r) % 4) + r)];
      end
    end
    return o;
  endfunction

  function automatic aes_blk_t inv_sub_bytes(input aes_blk_t s);
    aes_blk_t o;
    for (int unsigned n = 0; n < 16; n++) o[4'(n)] = inv_sbox(s[4'(n)]);
    return o;
  endfunction

  function automatic aes_blk_t inv_mix_columns(input aes_blk_t s);
    aes_blk_t o;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[4'(4 * c + r)] = gf_mul(s[4'(4 * c + r)], 8'h0e)
                         ^ gf_mul(s[4'(4 * c + (r + 1) % 4)], 8'h0b)
                         ^ gf_mul(s[4'(4 * c + (r + 2) % 4)], 8'h0d)
                         ^ gf_mul(s[4'(4 * c + (r + 3) % 4)], 8'h09);
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/inv_cipher_ctrl_if.sv
// Ciphertext-in / plaintext-out streams plus the round-key lookup port of the controller.
interface inv_cipher_ctrl_if;
  import inv_cipher_ctrl_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [AesBlkW-1:0] in_data;
  logic [RkIdxW-1:0]  rk_idx;
  logic [AesBlkW-1:0] round_key;
  logic               out_valid;
  logic               out_ready;
  logic [AesBlkW-1:0] out_data;
  logic               busy;

  modport master (
    output in_valid, in_data, round_key, out_ready,
    input  in_ready, rk_idx, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, round_key, out_ready,
    output in_ready, rk_idx, out_valid, out_data, busy
  );

endinterface

// File: rtl/inv_cipher_ctrl_round.sv
// One inverse-cipher round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
module inv_cipher_ctrl_round
  import inv_cipher_ctrl_pkg::*;
(
  input  aes_blk_t blk,
  input  aes_blk_t key,
  input  logic     last,
  output aes_blk_t result
);

  aes_blk_t keyed;

  always_comb begin
    keyed  = inv_sub_bytes(inv_shift_rows(blk)) ^ key;
    result = last ? keyed : inv_mix_columns(keyed);
  end

endmodule

// File: rtl/inv_cipher_ctrl.sv
// Iterative AES-128 decrypt controller: one round per clock, round keys fetched by index.
module inv_cipher_ctrl
  import inv_cipher_ctrl_pkg::*;
(
  input logic               clk,
  input logic               rst,
  inv_cipher_ctrl_if.slave  bus
);

  ctrl_state_e       state_q, state_d;
  logic [RkIdxW-1:0] rnd_q, rnd_d;
  aes_blk_t          st_q, st_d;
  aes_blk_t          out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  aes_blk_t          round_out;
  logic              last;
  logic              in_ready;
  logic [RkIdxW-1:0] rk_idx;

  assign last = (state_q == StFinal);

  inv_cipher_ctrl_round u_round (
    .blk    (st_q),
    .key    (bus.round_key),
    .last   (last),
    .result (round_out)
  );

  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    st_d        = st_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;
    rk_idx      = '0;
    case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        rk_idx   = RkIdxLast;
        if (bus.in_valid) begin
          st_d    = bus.in_data ^ bus.round_key;
          rnd_d   = RndFirst;
          state_d = StRound;
        end
      end
      StRound: begin
        rk_idx = rnd_q;
        // Unreachable counter values abandon the block rather than wrapping.
        if (rnd_q == '0 || rnd_q > RndFirst) begin
          state_d = StIdle;
        end else begin
          st_d = round_out;
          if (rnd_q == 4'd1) state_d = StFinal;
          else               rnd_d   = rnd_q - 4'd1;
        end
      end
      StFinal: begin
        out_data_d  = round_out;
        out_valid_d = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rnd_q       <= '0;
      st_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      st_q        <= st_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.rk_idx    = rk_idx;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_inv_cipher_ctrl.sv
// Bench for inv_cipher_ctrl: FIPS-197 vectors, handshake corners, and forward-cipher generated blocks.
module tb_inv_cipher_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  inv_cipher_ctrl_if bus ();

  inv_cipher_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic [127:0] rk [0:10];
  int n_vec = 0;
  int n_err = 0;

  assign bus.round_key = (bus.rk_idx <= 4'd10) ? rk[bus.rk_idx] : '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Key store contents: forward AES-128 key schedule.
  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32 * (3 - i) +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  // Forward cipher: random blocks are generated as plaintext and encrypted here.
  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [0:15][7:0] s;
    logic [0:15][7:0] t;
    logic [7:0] a0, a1, a2, a3;
    s = pt ^ rk[0];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          t[4'(4 * c + rr)] = SBOX[s[4'(4 * ((c + rr) % 4) + rr)]];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4'(4 * c)]; a1 = t[4'(4 * c + 1)]; a2 = t[4'(4 * c + 2)]; a3 = t[4'(4 * c + 3)];
          s[4'(4 * c)]     = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4'(4 * c + 1)] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4'(4 * c + 2)] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4'(4 * c + 3)] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end else begin
        s = t;
      end
      s = s ^ rk[r];
    end
    return s;
  endfunction

  // From the accepting edge, wait for out_valid while checking the key-index trace 9..0.
  task automatic wait_result(input string tag, input bit noise, output int cyc);
    bit rk_ok;
    rk_ok = 1'b1;
    cyc   = 0;
    while (!bus.out_valid && cyc < 20) begin
      if (bus.rk_idx !== 4'(9 - cyc) || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) rk_ok = 1'b0;
      if (noise) begin
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.in_data   = {$urandom, $urandom, $urandom, $urandom};
        bus.out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    check({tag, " rk trace"}, 128'(rk_ok), 128'd1);
    check({tag, " latency"}, 128'(cyc), 128'd10);
  endtask

  task automatic do_block(input logic [127:0] ct, input logic [127:0] pt, input int stall,
                          input bit noise, input string tag);
    int cyc;
    bit hold_ok;
    logic [127:0] held;
    check({tag, " in_ready idle"}, 128'(bus.in_ready), 128'd1);
    check({tag, " rk_idx idle"}, 128'(bus.rk_idx), 128'd10);
    bus.in_valid  = 1'b1;
    bus.in_data   = ct;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_result(tag, noise, cyc);
    bus.out_ready = 1'b0;
    if (cyc >= 20) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    held    = bus.out_data;
    hold_ok = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.out_data !== held || bus.in_ready !== 1'b0 ||
          bus.busy !== 1'b1) hold_ok = 1'b0;
    end
    check({tag, " hold"}, 128'(hold_ok), 128'd1);
    check({tag, " out_data"}, bus.out_data, pt);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, " released out_valid"}, 128'(bus.out_valid), 128'd0);
    check({tag, " released in_ready"}, 128'(bus.in_ready), 128'd1);
  endtask

  task automatic back_to_back(input logic [127:0] ct1, input logic [127:0] pt1,
                              input logic [127:0] ct2, input logic [127:0] pt2);
    int val_at;
    int rdy_at;
    int cyc;
    logic [127:0] got1;
    val_at = 0;
    rdy_at = 0;
    got1   = '0;
    bus.in_valid  = 1'b1;
    bus.in_data   = ct1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_data = ct2;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus.out_valid && val_at == 0) begin
        val_at = k;
        got1   = bus.out_data;
      end
      if (bus.in_ready) begin
        rdy_at = k;
        break;
      end
    end
    check("b2b first latency", 128'(val_at), 128'd10);
    check("b2b first out_data", got1, pt1);
    check("b2b second accept edge", 128'(rdy_at + 1), 128'd12);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("b2b second accepted", 128'(bus.in_ready), 128'd0);
    wait_result("b2b second", 1'b0, cyc);
    check("b2b second out_data", bus.out_data, pt2);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("b2b back to idle", 128'(bus.in_ready), 128'd1);
  endtask

  initial begin
    logic [127:0] pt;
    logic [127:0] ct;
    bit quiet;
    int n;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    set_key(C1_KEY);
    @(negedge clk);
    @(negedge clk);
    check("reset in_ready", 128'(bus.in_ready), 128'd1);
    check("reset out_valid", 128'(bus.out_valid), 128'd0);
    check("reset out_data", bus.out_data, 128'd0);
    check("reset busy", 128'(bus.busy), 128'd0);
    check("reset rk_idx", 128'(bus.rk_idx), 128'd10);

    // A handshake during reset must not be accepted.
    bus.in_valid = 1'b1;
    bus.in_data  = C1_CT;
    @(negedge clk);
    check("rst beats in_valid", 128'(bus.busy), 128'd0);
    bus.in_valid = 1'b0;
    rst = 1'b0;

    do_block(C1_CT, C1_PT, 0, 1'b0, "fips_c1");
    set_key(B_KEY);
    do_block(B_CT, B_PT, 5, 1'b0, "backpressure");

    set_key(C1_KEY);
    back_to_back(C1_CT, C1_PT, encrypt(B_PT), B_PT);

    // Abort in the middle of round 5.
    bus.in_valid = 1'b1;
    bus.in_data  = B_CT;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.rk_idx !== 4'd5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reach rnd 5", 128'(n), 128'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort in_ready", 128'(bus.in_ready), 128'd1);
    check("abort out_valid", 128'(bus.out_valid), 128'd0);
    check("abort busy", 128'(bus.busy), 128'd0);
    quiet = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
    end
    check("abort stays idle", 128'(quiet), 128'd1);
    do_block(C1_CT, C1_PT, 1, 1'b0, "after_abort");

    do_block(C1_CT, C1_PT, 2, 1'b1, "busy_ignore");

    for (int i = 0; i < 200; i++) begin
      set_key({$urandom, $urandom, $urandom, $urandom});
      pt = {$urandom, $urandom, $urandom, $urandom};
      ct = encrypt(pt);
      do_block(ct, pt, int'($urandom_range(0, 3)), 1'b1, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

endmodule
